// File: rtl/noc_path_computation_if.sv
// Handshake bundle for the hypercube router-ingress path computation stage.
// master drives packets and output readies; slave is the routing stage.
interface noc_path_computation_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 7
);
  localparam int FLIT_W = ADDR_W + DATA_W;
  localparam int RW     = $clog2(ADDR_W);

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              core_valid;
  logic              core_ready;
  logic [FLIT_W-1:0] core_flit;
  logic [ADDR_W-1:0] rtr_valid;
  logic [ADDR_W-1:0] rtr_ready;
  logic [FLIT_W-1:0] rtr_flit;
  logic              out_core;
  logic [RW-1:0]     out_router;

  modport master (
    output in_valid, in_addr, in_data,
    output core_ready, rtr_ready,
    input  in_ready, core_valid, core_flit,
    input  rtr_valid, rtr_flit,
    input  out_core, out_router
  );

  modport slave (
    input  in_valid, in_addr, in_data,
    input  core_ready, rtr_ready,
    output in_ready, core_valid, core_flit,
    output rtr_valid, rtr_flit,
    output out_core, out_router
  );
endinterface

// File: rtl/noc_path_computation.sv
// Single-entry routing stage: dimension-order port select per packet.
// Optional delivered-flit counters enabled by PC_STATS_EN.
module noc_path_computation #(
  parameter int              ADDR_W    = 4,
  parameter int              DATA_W    = 7,
  parameter logic [ADDR_W-1:0] NODE_ADDR = '0
) (
  input  logic clk,
  input  logic reset,
  noc_path_computation_if.slave bus
`ifdef PC_STATS_EN
  ,
  output logic [15:0]          stat_core,
  output logic [ADDR_W*16-1:0] stat_rtr
`endif
);
  localparam int FLIT_W = ADDR_W + DATA_W;
  localparam int RW     = $clog2(ADDR_W);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state;
  state_t            state_nx;
  logic [FLIT_W-1:0] flit_q;
  logic              core_q;
  logic [RW-1:0]     port_q;
  logic [ADDR_W-1:0] diff;
  logic              route_core;
  logic [RW-1:0]     route_port;
  logic              full;
  logic              dest_accept;
  logic              accept;

  assign full        = (state == FULL);
  assign dest_accept = core_q ? bus.core_ready
                              : bus.rtr_ready[port_q];
  assign bus.in_ready = !full || dest_accept;
  assign accept      = bus.in_valid && bus.in_ready;

  assign diff       = bus.in_addr ^ NODE_ADDR;
  assign route_core = (diff == '0);

  // lowest differing dimension wins
  always_comb begin
    route_port = '0;
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      if (diff[i]) route_port = RW'(i);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (accept) state_nx = FULL;
      FULL:  if (dest_accept && !bus.in_valid)
               state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_q <= '0;
      core_q <= 1'b0;
      port_q <= '0;
    end else if (accept) begin
      flit_q <= {bus.in_addr, bus.in_data};
      core_q <= route_core;
      port_q <= route_core ? '0 : route_port;
    end
  end

  assign bus.core_valid = full && core_q;
  assign bus.rtr_valid  = (full && !core_q)
                        ? (ADDR_W'(1) << port_q) : '0;
  assign bus.core_flit  = flit_q;
  assign bus.rtr_flit   = flit_q;
  assign bus.out_core   = core_q;
  assign bus.out_router = port_q;

`ifdef PC_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stat_core <= '0;
    else if (bus.core_valid && bus.core_ready
             && stat_core != 16'hFFFF)
      stat_core <= stat_core + 16'd1;
  end

  for (genvar k = 0; k < ADDR_W; k++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        cnt <= '0;
      else if (bus.rtr_valid[k] && bus.rtr_ready[k]
               && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end
    assign stat_rtr[k*16 +: 16] = cnt;
  end
`endif
endmodule

// File: tb/tb_noc_path_computation.sv
// Self-checking bench for noc_path_computation (NODE_ADDR = 0).
// Scoreboard of accepted packets, routed by lowest set bit of addr^node.
module tb_noc_path_computation;
  localparam logic [3:0] NODE = 4'b0000;
  localparam logic [6:0] D    = 7'b1111000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  noc_path_computation_if #(.ADDR_W(4), .DATA_W(7)) bus();

`ifdef PC_STATS_EN
  logic [15:0] stat_core;
  logic [63:0] stat_rtr;
`endif

  noc_path_computation #(
    .ADDR_W(4), .DATA_W(7), .NODE_ADDR(NODE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef PC_STATS_EN
    ,
    .stat_core(stat_core),
    .stat_rtr(stat_rtr)
`endif
  );

  always #5 clk = ~clk;

  // port 4 means the core; else the dimension index
  function automatic int exp_port(logic [3:0] a);
    logic [3:0] d;
    logic [3:0] lsb;
    d   = a ^ NODE;
    lsb = d & (~d + 4'd1);
    if (d == 4'd0) return 4;
    for (int k = 0; k < 4; k++)
      if (lsb == (4'b0001 << k)) return k;
    return -1;
  endfunction

  function automatic logic [15:0] exp_out(logic [10:0] f);
    int p;
    p = exp_port(f[10:7]);
    if (p == 4) return {1'b1, 4'b0000, f};
    return {1'b0, 4'b0001 << p, f};
  endfunction

  function automatic logic [15:0] got_out();
    logic [10:0] f;
    f = bus.core_valid ? bus.core_flit
      : (bus.rtr_valid != 4'd0) ? bus.rtr_flit : 11'd0;
    return {bus.core_valid, bus.rtr_valid, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_addr    = 4'd0;
    bus.in_data    = 7'd0;
    bus.core_ready = 1'b1;
    bus.rtr_ready  = 4'hF;
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [3:0] a, input logic [6:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.core_ready = 1'b0;
    bus.rtr_ready  = 4'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    total++;
    if (got_out() !== 16'd0
        || bus.core_flit !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h flit=%h exp=0",
               got_out(), bus.core_flit);
    end
    total++;
    if ({bus.out_core, bus.out_router} !== 3'b000) begin
      bad++;
      $display("FAIL reset_decision got=%b%b exp=000",
               bus.out_core, bus.out_router);
    end
    tick();
  endtask

  task automatic test_core();
    pulse_reset();
    send(4'b0000, D);
    #1;
    total++;
    if (got_out() !== {1'b1, 4'b0000, 11'b0000_1111000}
        || bus.out_core !== 1'b1) begin
      bad++;
      $display("FAIL core_route got=%h oc=%b exp=%h oc=1",
               got_out(), bus.out_core,
               {1'b1, 4'b0000, 11'b0000_1111000});
    end
    tick();
    total++;
    if (got_out() !== 16'd0 || bus.out_core !== 1'b1) begin
      bad++;
      $display("FAIL core_drain got=%h oc=%b exp=0 oc=1",
               got_out(), bus.out_core);
    end
  endtask

  task automatic test_dims();
    logic [3:0] a;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      a = 4'b0001 << i;
      send(a, D);
      #1;
      total++;
      if (got_out() !== {1'b0, a, a, D}
          || bus.out_core !== 1'b0
          || bus.out_router !== 2'(i)) begin
        bad++;
        $display("FAIL dim_%0d got=%h or=%0d exp=%h or=%0d",
                 i, got_out(), bus.out_router,
                 {1'b0, a, a, D}, i);
      end
      tick();
    end
  endtask

  task automatic test_lowest_bit();
    pulse_reset();
    send(4'b0110, D);
    #1;
    total++;
    if (bus.rtr_valid !== 4'b0010 || bus.out_router !== 2'd1
        || bus.rtr_flit !== {4'b0110, D}) begin
      bad++;
      $display("FAIL lowest_bit rv=%b or=%0d exp rv=0010 or=1",
               bus.rtr_valid, bus.out_router);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [6:0] d1;
    logic [6:0] d2;
    pulse_reset();
    d1 = 7'h15;
    d2 = 7'h6A;
    bus.rtr_ready = 4'b1110;
    send(4'b0001, d1);
    bus.in_valid = 1'b1;
    bus.in_addr  = 4'b0010;
    bus.in_data  = d2;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (got_out() !== {1'b0, 4'b0001, 4'b0001, d1}
          || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_%0d got=%h rdy=%b exp=%h rdy=0",
                 c, got_out(), bus.in_ready,
                 {1'b0, 4'b0001, 4'b0001, d1});
      end
      tick();
    end
    bus.rtr_ready = 4'hF;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release rdy=%b exp=1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (got_out() !== {1'b0, 4'b0010, 4'b0010, d2}) begin
      bad++;
      $display("FAIL stall_second got=%h exp=%h",
               got_out(), {1'b0, 4'b0010, 4'b0010, d2});
    end
    tick();
    total++;
    if (got_out() !== 16'd0) begin
      bad++;
      $display("FAIL stall_empty got=%h exp=0", got_out());
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    bus.rtr_ready = 4'h0;
    send(4'b0100, D);
    #1;
    total++;
    if (bus.rtr_valid !== 4'b0100) begin
      bad++;
      $display("FAIL mid_held rv=%b exp=0100", bus.rtr_valid);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (got_out() !== 16'd0 || bus.core_flit !== 11'd0
        || {bus.out_core, bus.out_router} !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset got=%h oc=%b or=%0d exp=0",
               got_out(), bus.out_core, bus.out_router);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.rtr_ready = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (got_out() !== 16'd0 || bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL mid_discard_%0d got=%h rdy=%b exp=0 rdy=1",
                 c, got_out(), bus.in_ready);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] prev;
    pulse_reset();
    prev = '0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = 4'($urandom);
      bus.in_data  = 7'($urandom);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready_%0d got=%b exp=1", i, bus.in_ready);
      end
      if (i > 0) begin
        total++;
        if (got_out() !== exp_out(prev)) begin
          bad++;
          $display("FAIL b2b_out_%0d got=%h exp=%h",
                   i, got_out(), exp_out(prev));
        end
      end
      prev = {bus.in_addr, bus.in_data};
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (got_out() !== exp_out(prev)) begin
      bad++;
      $display("FAIL b2b_last got=%h exp=%h", got_out(), exp_out(prev));
    end
    tick();
  endtask

  task automatic test_random();
    logic [10:0] sb[$];
    logic [15:0] snap;
    logic        stalled;
    logic        acc;
    logic        hs;
    int          nv;
    int          lp;
    pulse_reset();
    stalled = 1'b0;
    acc     = 1'b1;
    snap    = '0;
    lp      = -1;
    for (int c = 0; c < 400; c++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_addr  = ($urandom_range(0, 4) == 0)
                     ? NODE : 4'($urandom);
        bus.in_data  = 7'($urandom);
      end
      bus.core_ready = ($urandom_range(0, 3) != 0);
      bus.rtr_ready  = 4'($urandom);
      #1;
      nv = int'(bus.core_valid) + $countones(bus.rtr_valid);
      total++;
      if (nv > 1) begin
        bad++;
        $display("FAIL rnd_onehot c=%0d got=%h", c, got_out());
      end
      if (stalled) begin
        total++;
        if (got_out() !== snap) begin
          bad++;
          $display("FAIL rnd_stable c=%0d got=%h exp=%h",
                   c, got_out(), snap);
        end
      end
      hs = (bus.core_valid && bus.core_ready)
        || ((bus.rtr_valid & bus.rtr_ready) != 4'd0);
      if (hs) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rnd_spurious c=%0d got=%h exp=none",
                   c, got_out());
        end else begin
          if (got_out() !== exp_out(sb[0])) begin
            bad++;
            $display("FAIL rnd_out c=%0d got=%h exp=%h",
                     c, got_out(), exp_out(sb[0]));
          end
          void'(sb.pop_front());
        end
      end
      total++;
      if (bus.in_ready !== (nv == 0 || hs)) begin
        bad++;
        $display("FAIL rnd_in_ready c=%0d got=%b exp=%b",
                 c, bus.in_ready, (nv == 0 || hs));
      end
      if (lp >= 0) begin
        total++;
        if ({bus.out_core, bus.out_router}
            !== {lp == 4, 2'((lp == 4) ? 0 : lp)}) begin
          bad++;
          $display("FAIL rnd_decision c=%0d got=%b%b exp_port=%0d",
                   c, bus.out_core, bus.out_router, lp);
        end
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        sb.push_back({bus.in_addr, bus.in_data});
        lp = exp_port(bus.in_addr);
      end
      stalled = (nv == 1) && !hs;
      snap    = got_out();
      tick();
    end
    bus.in_valid   = 1'b0;
    bus.core_ready = 1'b1;
    bus.rtr_ready  = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (got_out() != 16'd0) begin
        total++;
        if (sb.size() == 0 || got_out() !== exp_out(sb[0])) begin
          bad++;
          $display("FAIL rnd_drain c=%0d got=%h", c, got_out());
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      tick();
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL rnd_lost got=%0d exp=0 pending", sb.size());
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_core();
    test_dims();
    test_lowest_bit();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
